// File: rtl/warp_issue_scheduler_if.sv
// ----------------------------------------------------------------------------
// warp_issue_scheduler_if : config, completion and issue-slot signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface warp_issue_scheduler_if #(
  parameter int NUM_WARPS = 8,
  parameter int WARP_SIZE = 32,
  parameter int WID_WIDTH = 3,
  parameter int CNT_WIDTH = 6
);
  logic                 cfg_we;
  logic [WID_WIDTH-1:0] cfg_wid;
  logic [WARP_SIZE-1:0] cfg_mask;
  logic [NUM_WARPS-1:0] warp_rdy;
  logic                 done_valid;
  logic [WID_WIDTH-1:0] done_wid;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [WID_WIDTH-1:0] iss_wid;
  logic [WARP_SIZE-1:0] iss_mask;
  logic [CNT_WIDTH-1:0] iss_count;
  logic [NUM_WARPS-1:0] busy;

  // Scheduler side
  modport master (
    input  cfg_we, cfg_wid, cfg_mask, warp_rdy, done_valid, done_wid, iss_ready,
    output iss_valid, iss_wid, iss_mask, iss_count, busy
  );

  // Config / execute side
  modport slave (
    output cfg_we, cfg_wid, cfg_mask, warp_rdy, done_valid, done_wid, iss_ready,
    input  iss_valid, iss_wid, iss_mask, iss_count, busy
  );
endinterface

`default_nettype wire

// File: rtl/warp_issue_scheduler.sv
// ----------------------------------------------------------------------------
// warp_issue_scheduler : round-robin warp picker with registered issue slot
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module warp_issue_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int WARP_SIZE = 32,
  parameter int WID_WIDTH = 3,
  parameter int CNT_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  warp_issue_scheduler_if.master  bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                               state_q, state_d;
  logic [NUM_WARPS-1:0][WARP_SIZE-1:0]  mask_q, mask_d;
  logic [NUM_WARPS-1:0]                 busy_q, busy_d;
  logic [WID_WIDTH-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [WID_WIDTH-1:0]                 wid_q, wid_d;
  logic [WARP_SIZE-1:0]                 iss_mask_q, iss_mask_d;
  logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;

  logic [NUM_WARPS-1:0]                 eligible;
  logic [WID_WIDTH-1:0]                 sel_wid;
  logic                                 sel_found;
  logic [CNT_WIDTH-1:0]                 sel_cnt;
  logic                                 load;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_elig
    assign eligible[w] = bus.warp_rdy[w] & (|mask_q[w]) & ~busy_q[w];
  end

  // Scan starts just past the last winner; index wraps naturally at WID_WIDTH.
  always_comb begin
    logic [WID_WIDTH-1:0] idx;
    sel_wid   = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = rr_ptr_q + WID_WIDTH'(i);
      if (!sel_found && eligible[idx]) begin
        sel_wid   = idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_cnt = '0;
    for (int b = 0; b < WARP_SIZE; b++) begin
      sel_cnt = sel_cnt + CNT_WIDTH'(mask_q[sel_wid][b]);
    end
  end

  assign load = sel_found & ((state_q == ST_EMPTY) | bus.iss_ready);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    wid_d      = wid_q;
    iss_mask_d = iss_mask_q;
    cnt_d      = cnt_q;

    if (bus.cfg_we) begin
      mask_d[bus.cfg_wid] = bus.cfg_mask;
    end

    if (bus.done_valid) begin
      busy_d[bus.done_wid] = 1'b0;
    end

    // A loaded warp was not busy, so it cannot collide with the done clear.
    if (load) begin
      busy_d[sel_wid] = 1'b1;
      rr_ptr_d        = sel_wid;
      wid_d           = sel_wid;
      iss_mask_d      = mask_q[sel_wid];
      cnt_d           = sel_cnt;
      state_d         = ST_FULL;
    end else if ((state_q == ST_FULL) && bus.iss_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      mask_q     <= '0;
      busy_q     <= '0;
      rr_ptr_q   <= WID_WIDTH'(NUM_WARPS - 1);
      wid_q      <= '0;
      iss_mask_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      wid_q      <= wid_d;
      iss_mask_q <= iss_mask_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.iss_valid = (state_q == ST_FULL);
  assign bus.iss_wid   = wid_q;
  assign bus.iss_mask  = iss_mask_q;
  assign bus.iss_count = cnt_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_warp_issue_scheduler.sv
// ----------------------------------------------------------------------------
// tb_warp_issue_scheduler : directed + random scoreboard bench
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_warp_issue_scheduler;
  localparam int NW = 8;
  localparam int WS = 32;
  localparam int WW = 3;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  warp_issue_scheduler_if #(.NUM_WARPS(NW), .WARP_SIZE(WS), .WID_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

  warp_issue_scheduler #(.NUM_WARPS(NW), .WARP_SIZE(WS), .WID_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          wid;
    logic [31:0] mask;
    int          cnt;
  } iss_t;

  iss_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  // Reference state: what the scheduler should hold after the last edge.
  logic [31:0] m_mask [NW];
  bit          m_busy [NW];
  int          m_last;
  bit          m_full;
  int          m_wid;
  logic [31:0] m_msk;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int w = 0; w < NW; w++) v[w] = m_busy[w];
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_mask[w] = '0;
      m_busy[w] = 1'b0;
    end
    m_last = NW - 1;
    m_full = 1'b0;
    m_wid  = 0;
    m_msk  = '0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit   elig [NW];
    bit   any;
    bit   ld;
    int   pick;
    iss_t it;
    if (!rst_n) begin
      model_reset();
      return;
    end
    any = 1'b0;
    for (int w = 0; w < NW; w++) begin
      elig[w] = bus.warp_rdy[w] && (m_mask[w] != 0) && !m_busy[w];
      if (elig[w]) any = 1'b1;
    end
    ld   = any && (!m_full || bus.iss_ready);
    pick = -1;
    if (ld) begin
      for (int k = 1; k <= NW; k++) begin
        int w;
        w = (m_last + k) % NW;
        if (pick < 0 && elig[w]) pick = w;
      end
    end
    if (bus.done_valid) m_busy[bus.done_wid] = 1'b0;
    if (ld) begin
      m_busy[pick] = 1'b1;
      m_last = pick;
      m_full = 1'b1;
      m_wid  = pick;
      m_msk  = m_mask[pick];
      m_cnt  = $countones(m_mask[pick]);
      it.wid = m_wid; it.mask = m_msk; it.cnt = m_cnt;
      exp_q.push_back(it);
    end else if (m_full && bus.iss_ready) begin
      m_full = 1'b0;
    end
    if (bus.cfg_we) m_mask[bus.cfg_wid] = bus.cfg_mask;
  endtask

  // Inputs already applied at posedge+1; check at posedge+7, then advance the model.
  task automatic tick();
    #6;
    chk("valid", 64'(bus.iss_valid), 64'(m_full));
    chk("busy",  64'(bus.busy),      64'(busy_vec()));
    chk("wid",   64'(bus.iss_wid),   64'(m_wid));
    chk("mask",  64'(bus.iss_mask),  64'(m_msk));
    chk("count", 64'(bus.iss_count), 64'(m_cnt));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int w, input logic [31:0] m);
    bus.cfg_we = 1'b1; bus.cfg_wid = WW'(w); bus.cfg_mask = m;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_wid = '0; bus.cfg_mask = '0;
    bus.warp_rdy = '0; bus.done_valid = 1'b0; bus.done_wid = '0;
    bus.iss_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: whatever sits in a valid slot must be the oldest expected issue.
  always @(negedge clk) begin
    if (started && bus.iss_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL slot: unexpected issue wid=%0d with empty scoreboard at %0t", bus.iss_wid, $time);
      end else begin
        chk("sb_wid",   64'(bus.iss_wid),   64'(exp_q[0].wid));
        chk("sb_mask",  64'(bus.iss_mask),  64'(exp_q[0].mask));
        chk("sb_count", 64'(bus.iss_count), 64'(exp_q[0].cnt));
        if (bus.iss_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    started = 1'b1;

    // 1: two warps, full-rate accept, then nothing more
    do_reset();
    cfg(0, 32'h0000_00FF);
    cfg(1, 32'hFFFF_FFFF);
    bus.warp_rdy = 8'h03; bus.iss_ready = 1'b1;
    repeat (6) tick();
    chk("t1_busy",  64'(bus.busy), 64'h03);
    chk("t1_valid", 64'(bus.iss_valid), 64'h0);

    // 2: all warps single-lane, completion returned for each accepted warp
    do_reset();
    for (int w = 0; w < NW; w++) cfg(w, 32'h1);
    bus.warp_rdy = 8'hFF; bus.iss_ready = 1'b1;
    repeat (12) begin
      bus.done_valid = m_full; bus.done_wid = WW'(m_wid);
      tick();
    end
    bus.done_valid = 1'b0;

    // 3: hold w2 for several cycles, overwrite its mask mid-hold
    do_reset();
    cfg(1, 32'h0000_0F0F);
    cfg(2, 32'h00FF_00F0);
    cfg(3, 32'h0000_0003);
    bus.warp_rdy = 8'h04; bus.iss_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.warp_rdy = 8'h0E;
      if (i == 2) begin bus.cfg_we = 1'b1; bus.cfg_wid = 3'd2; bus.cfg_mask = 32'h0; end
      tick();
      bus.cfg_we = 1'b0;
    end
    bus.iss_ready = 1'b1;
    repeat (4) tick();

    // 4: completion arriving while the warp is still ready
    do_reset();
    cfg(3, 32'h0000_00F0);
    bus.warp_rdy = 8'h08; bus.iss_ready = 1'b1;
    repeat (4) tick();
    bus.done_valid = 1'b1; bus.done_wid = 3'd3;
    tick();
    bus.done_valid = 1'b0;
    repeat (3) tick();

    // 5: ready warps with empty masks, stray completion
    do_reset();
    bus.warp_rdy = 8'hFF; bus.iss_ready = 1'b1;
    repeat (3) tick();
    bus.done_valid = 1'b1; bus.done_wid = 3'd5;
    tick();
    bus.done_valid = 1'b0;
    tick();
    chk("t5_valid", 64'(bus.iss_valid), 64'h0);
    chk("t5_busy",  64'(bus.busy), 64'h0);

    // 6: reset while the slot is full and four warps are busy
    do_reset();
    for (int w = 0; w < 4; w++) cfg(w, 32'h3 << w);
    bus.warp_rdy = 8'h0F; bus.iss_ready = 1'b1;
    repeat (4) tick();
    bus.iss_ready = 1'b0;
    tick();
    chk("t6_busy",  64'(bus.busy), 64'h0F);
    chk("t6_valid", 64'(bus.iss_valid), 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.warp_rdy = 8'h00; bus.iss_ready = 1'b1;
    tick();
    cfg(5, 32'h8000_0001);
    cfg(2, 32'h0000_FFFF);
    bus.warp_rdy = 8'h24;
    repeat (4) tick();

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int sel;
      rst_n = ($urandom_range(0, 99) != 0);
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_wid = WW'($urandom_range(0, NW - 1));
      sel = $urandom_range(0, 3);
      case (sel)
        0: bus.cfg_mask = 32'h0;
        1: bus.cfg_mask = 32'hFFFF_FFFF;
        2: bus.cfg_mask = 32'h1 << $urandom_range(0, 31);
        default: bus.cfg_mask = $urandom;
      endcase
      bus.warp_rdy   = 8'($urandom);
      bus.iss_ready  = ($urandom_range(0, 3) != 0);
      bus.done_valid = ($urandom_range(0, 1) == 1);
      bus.done_wid   = WW'($urandom_range(0, NW - 1));
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();

    chk("sb_left", 64'(exp_q.size()), 64'(m_full ? 1 : 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish by %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
